// File: rtl/bitblaster_pkg.sv
// Shared types and seven-segment constants for the BitBlaster board output path.
package bitblaster_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } conv_state_t;

   typedef logic [3:0] bcd_digit_t;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_LUT [0:9] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   function automatic logic [6:0] seg_encode(input bcd_digit_t digit);
      logic [6:0] seg;
      seg = SEG_BLANK;
      if (digit <= 4'd9) seg = SEG_LUT[digit];
      return seg;
   endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment pattern, with forced blanking.
module seg7_decoder
   import bitblaster_pkg::*;
(
   input  bcd_digit_t  digit,
   input  logic        blank,
   output logic [6:0]  seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank) seg = seg_encode(digit);
   end

endmodule

// File: rtl/output_logic.sv
// BitBlaster output path: edge-triggered capture of the databus onto the LEDs, and a
// sequential double-dabble conversion of the selected value onto four 7-segment digits.
module output_logic
   import bitblaster_pkg::*;
#(
   parameter int DATA_W        = 10,
   parameter bit BLANK_LEADING = 1'b1
)
(
   input  logic              CLK_50MHz,
   input  logic              Reset_n,
   input  logic [DATA_W-1:0] databus,
   input  logic              Out_Enable,
   input  logic              PeeKb,
   output logic [DATA_W-1:0] LEDR,
   output logic [6:0]        HEX0,
   output logic [6:0]        HEX1,
   output logic [6:0]        HEX2,
   output logic [6:0]        HEX3,
   output logic              Busy
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   conv_state_t       state_reg, state_next;
   logic              en_reg;
   logic [DATA_W-1:0] out_reg, ledr_reg;
   logic [DATA_W-1:0] snap_reg, snap_next;
   logic [DATA_W-1:0] work_reg, work_next;
   logic [15:0]       bcd_reg, bcd_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [DATA_W-1:0] last_val_reg, last_val_next;
   logic              last_valid_reg, last_valid_next;
   logic              hex_load;
   logic [6:0]        hex_reg [4];
   logic [6:0]        seg [4];

   logic [DATA_W-1:0]    src;
   logic                 capture;
   logic [15:0]          bcd_adj;
   logic [16+DATA_W-1:0] shift_cat;
   logic [4:0]           blank_chain;

   assign src     = PeeKb ? databus : out_reg;
   assign capture = Out_Enable && !en_reg;

   // Add-3 correction on every nibble before the shift
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_adj
         assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                     bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
      end
   endgenerate

   assign shift_cat = {bcd_adj, work_reg} << 1;

   // A digit blanks only when it and every higher digit are zero; HEX0 never blanks
   assign blank_chain[4] = 1'b1;
   assign blank_chain[0] = 1'b0;
   generate
      for (gi = 1; gi < 4; gi++) begin : g_blank
         assign blank_chain[gi] = BLANK_LEADING && (bcd_reg[4*gi +: 4] == 4'd0) &&
                                  blank_chain[gi+1];
      end
      for (gi = 0; gi < 4; gi++) begin : g_dec
         seg7_decoder u_dec (
            .digit (bcd_digit_t'(bcd_reg[4*gi +: 4])),
            .blank (blank_chain[gi]),
            .seg   (seg[gi])
         );
      end
   endgenerate

   always_comb begin
      state_next      = state_reg;
      snap_next       = snap_reg;
      work_next       = work_reg;
      bcd_next        = bcd_reg;
      cnt_next        = cnt_reg;
      last_val_next   = last_val_reg;
      last_valid_next = last_valid_reg;
      hex_load        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!last_valid_reg || (src != last_val_reg)) begin
               state_next = SHIFT;
               snap_next  = src;
               work_next  = src;
               bcd_next   = '0;
               cnt_next   = CNT_W'(DATA_W - 1);
            end
         end
         SHIFT: begin
            bcd_next  = shift_cat[16+DATA_W-1 -: 16];
            work_next = shift_cat[DATA_W-1:0];
            if (cnt_reg == '0) state_next = DONE;
            else               cnt_next   = cnt_reg - 1'b1;
         end
         DONE: begin
            hex_load        = 1'b1;
            last_val_next   = snap_reg;
            last_valid_next = 1'b1;
            state_next      = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK_50MHz or negedge Reset_n) begin
      if (!Reset_n) begin
         state_reg      <= IDLE;
         en_reg         <= 1'b0;
         out_reg        <= '0;
         ledr_reg       <= '0;
         snap_reg       <= '0;
         work_reg       <= '0;
         bcd_reg        <= '0;
         cnt_reg        <= '0;
         last_val_reg   <= '0;
         last_valid_reg <= 1'b0;
         for (int i = 0; i < 4; i++) hex_reg[i] <= SEG_BLANK;
      end else begin
         en_reg <= Out_Enable;
         if (capture) begin
            out_reg  <= databus;
            ledr_reg <= databus;
         end
         state_reg      <= state_next;
         snap_reg       <= snap_next;
         work_reg       <= work_next;
         bcd_reg        <= bcd_next;
         cnt_reg        <= cnt_next;
         last_val_reg   <= last_val_next;
         last_valid_reg <= last_valid_next;
         if (hex_load) begin
            for (int i = 0; i < 4; i++) hex_reg[i] <= seg[i];
         end
      end
   end

   assign LEDR = ledr_reg;
   assign HEX0 = hex_reg[0];
   assign HEX1 = hex_reg[1];
   assign HEX2 = hex_reg[2];
   assign HEX3 = hex_reg[3];
   assign Busy = (state_reg != IDLE);

endmodule

// File: tb/tb_output_logic.sv
// Scoreboard bench for output_logic: stimulus queues expected displays, a monitor checks
// each completed conversion (Busy falling) for digit values and completion cycle.
module tb_output_logic;

   logic       clk = 1'b0;
   logic       Reset_n;
   logic [9:0] databus;
   logic       Out_Enable;
   logic       PeeKb;
   logic [9:0] LEDR;
   logic [6:0] HEX0, HEX1, HEX2, HEX3;
   logic       Busy;

   typedef struct {
      logic [27:0] hex;   // {HEX3,HEX2,HEX1,HEX0}
      int          due;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   logic busy_prev = 1'b0;

   output_logic #(.DATA_W(10), .BLANK_LEADING(1'b1)) dut (
      .CLK_50MHz  (clk),
      .Reset_n    (Reset_n),
      .databus    (databus),
      .Out_Enable (Out_Enable),
      .PeeKb      (PeeKb),
      .LEDR       (LEDR),
      .HEX0       (HEX0),
      .HEX1       (HEX1),
      .HEX2       (HEX2),
      .HEX3       (HEX3),
      .Busy       (Busy)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end else begin
         $display("ok   %s value=%h", name, act);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [6:0] h3, input logic [6:0] h2,
                           input logic [6:0] h1, input logic [6:0] h0, input int due);
      exp_t e;
      e.hex = {h3, h2, h1, h0};
      e.due = due;
      exp_q.push_back(e);
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         step();
         n++;
      end
      check("drain_pending", exp_q.size(), 0);
      exp_q.delete();
      repeat (2) step();
   endtask

   // Monitor: a Busy 1->0 transition marks a DONE edge where HEX was loaded
   always @(negedge clk) begin
      if (!Reset_n) begin
         busy_prev = 1'b0;
      end else begin
         if (busy_prev && !Busy) begin
            if (exp_q.size() == 0) begin
               check("unexpected_conversion", {4'h0, HEX3, HEX2, HEX1, HEX0}, 32'hFFFFFFFF);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("hex_value", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, e.hex});
               check("hex_cycle", cyc, e.due);
            end
         end
         busy_prev = Busy;
      end
   end

   initial begin
      Reset_n    = 1'b0;
      databus    = '0;
      Out_Enable = 1'b0;
      PeeKb      = 1'b0;
      repeat (3) step();

      // Reset state
      check("rst_ledr", LEDR, 0);
      check("rst_hex", {HEX3, HEX2, HEX1, HEX0}, 28'hFFF_FFFF);
      check("rst_busy", Busy, 0);

      // Release: first conversion of src=0
      Reset_n = 1'b1;
      push_exp(7'h7F, 7'h7F, 7'h7F, 7'h40, cyc + 12);
      wait_drain(40);

      // Capture 1023
      databus = 10'd1023; Out_Enable = 1'b1;
      push_exp(7'h79, 7'h40, 7'h24, 7'h30, cyc + 13);
      step();
      check("cap_1023_ledr", LEDR, 10'h3FF);
      Out_Enable = 1'b0;
      wait_drain(40);

      // out_reg=5, then peek 42, then back to 5
      databus = 10'd5; Out_Enable = 1'b1;
      push_exp(7'h7F, 7'h7F, 7'h7F, 7'h12, cyc + 13);
      step();
      Out_Enable = 1'b0;
      wait_drain(40);
      databus = 10'd42; PeeKb = 1'b1;
      push_exp(7'h7F, 7'h7F, 7'h19, 7'h24, cyc + 12);
      wait_drain(40);
      check("peek_ledr_kept", LEDR, 10'd5);
      PeeKb = 1'b0;
      push_exp(7'h7F, 7'h7F, 7'h7F, 7'h12, cyc + 12);
      wait_drain(40);

      // Capture and peek in the same cycle; releasing peek then needs no reconversion
      databus = 10'd9; Out_Enable = 1'b1; PeeKb = 1'b1;
      push_exp(7'h7F, 7'h7F, 7'h7F, 7'h10, cyc + 12);
      step();
      Out_Enable = 1'b0;
      check("cap_peek_ledr", LEDR, 10'd9);
      wait_drain(40);
      PeeKb = 1'b0;
      repeat (15) step();
      check("no_reconv_busy", Busy, 0);

      // Source changes during SHIFT: 100 shown first, then 7
      databus = 10'd100; PeeKb = 1'b1;
      push_exp(7'h7F, 7'h79, 7'h40, 7'h40, cyc + 12);
      push_exp(7'h7F, 7'h7F, 7'h7F, 7'h78, cyc + 24);
      repeat (5) step();
      check("mid_shift_busy", Busy, 1);
      databus = 10'd7;
      wait_drain(60);
      PeeKb = 1'b0;
      push_exp(7'h7F, 7'h7F, 7'h7F, 7'h10, cyc + 12);
      wait_drain(40);

      // Out_Enable held high for 20 cycles while databus counts: only 1 is captured
      databus = 10'd1; Out_Enable = 1'b1;
      push_exp(7'h7F, 7'h7F, 7'h7F, 7'h79, cyc + 13);
      for (int v = 2; v <= 20; v++) begin
         step();
         databus = 10'(v);
      end
      step();
      Out_Enable = 1'b0;
      check("held_enable_ledr", LEDR, 10'd1);
      wait_drain(40);

      // Asynchronous reset in the middle of a conversion
      databus = 10'd777; Out_Enable = 1'b1;
      step();
      Out_Enable = 1'b0;
      check("cap_777_ledr", LEDR, 10'd777);
      repeat (3) step();
      #2;
      Reset_n = 1'b0;
      #1;
      check("async_rst_hex", {HEX3, HEX2, HEX1, HEX0}, 28'hFFF_FFFF);
      check("async_rst_busy", Busy, 0);
      check("async_rst_ledr", LEDR, 0);
      step();
      Reset_n = 1'b1;
      push_exp(7'h7F, 7'h7F, 7'h7F, 7'h40, cyc + 12);
      wait_drain(40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
